uart_tx_framed: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter. It takes bytes through a valid/ready handshake into a small FIFO and serialises them LSB-first. The frame format is selected at runtime: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits. It sits between the CPU MMIO UART registers and the board TX pin, so software can queue bytes without polling per character.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_framed.sv | 141 ++++++++++++++
 tb/tb_uart_tx_framed.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot transmit FSM encoding, frame-format codes
// and the baud timing helper.
package uart_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } tx_state_e;

    localparam logic [1:0] PAR_NONE     = 2'd0;
    localparam logic [1:0] PAR_EVEN     = 2'd1;
    localparam logic [1:0] PAR_ODD      = 2'd2;
    localparam logic [1:0] PAR_NONE_ALT = 2'd3;

    // cfg_data_bits code 0..3 selects DBITS_MIN..DBITS_MIN+3 data bits
    localparam int unsigned DBITS_MIN = 5;

    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; pointers and count clear on reset,
// so queued contents are discarded. Shared by the UART transmit and receive paths.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter with runtime frame format (5-8 data bits, none/even/odd
// parity, 1/2 stop bits) fed from a byte FIFO; frames go out back-to-back.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          serial_out
);
    localparam int unsigned   SET      = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned   CW       = (SET > 1) ? $clog2(SET) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SET - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, last_bit_q, last_bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
    logic          serial_q, serial_d;
    logic          fifo_pop, fifo_empty, fifo_full, load, wrap;
    logic [7:0]    fifo_rdata, data_mask;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (data_in_valid && data_in_ready),
        .wdata_i (data_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign data_in_ready = !fifo_full;
    assign busy          = (state_q != ST_IDLE) || (fifo_count != '0);
    assign serial_out    = serial_q;
    assign wrap          = (clk_cnt_q == CNT_LAST);
    assign data_mask     = 8'hFF >> (2'd3 - cfg_data_bits);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            serial_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            serial_q   <= serial_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        load       = 1'b0;
        if (state_q != ST_IDLE) clk_cnt_d = wrap ? '0 : clk_cnt_q + CW'(1);
        case (state_q)
            ST_IDLE:   load = !fifo_empty;
            ST_START: if (wrap) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
            end
            ST_DATA: if (wrap) begin
                shreg_d = shreg_q >> 1;
                if (bit_cnt_q == last_bit_q) begin
                    state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_PARITY: if (wrap) begin
                state_d   = ST_STOP;
                bit_cnt_d = '0;
            end
            ST_STOP: if (wrap) begin
                if (stop2_q && bit_cnt_q == '0) bit_cnt_d = 3'd1;
                else if (!fifo_empty)            load      = 1'b1;
                else                             state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
            end
        endcase
        // Frame format is captured here so cfg changes only affect the next frame
        if (load) begin
            state_d    = ST_START;
            clk_cnt_d  = '0;
            shreg_d    = fifo_rdata & data_mask;
            last_bit_d = 3'(DBITS_MIN - 1) + {1'b0, cfg_data_bits};
            par_en_d   = !(cfg_parity inside {PAR_NONE, PAR_NONE_ALT});
            par_bit_d  = (^(fifo_rdata & data_mask)) ^ (cfg_parity == PAR_ODD);
            stop2_d    = cfg_stop2;
        end
    end

    assign fifo_pop = load;

    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shreg_d[0];
            ST_PARITY: serial_d = par_bit_d;
            default:   serial_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench: accepted bytes are queued with their accept cycle; a monitor
// predicts line, busy, fifo_count and ready every cycle from frame-format rules.
module tb_uart_tx_framed;
    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int FD  = 4;
    localparam int SET = CF / BR;

    logic                clk, reset;
    logic [7:0]          data_in;
    logic                data_in_valid, data_in_ready;
    logic [1:0]          cfg_data_bits, cfg_parity;
    logic                cfg_stop2;
    logic [$clog2(FD):0] fifo_count;
    logic                busy, serial_out;

    uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(FD)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .fifo_count    (fifo_count),
        .busy          (busy),
        .serial_out    (serial_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] d;
        int         acc;
    } ent_t;

    ent_t        sbq[$];
    int          vectors = 0, miscompares = 0;
    int          cyc = 0;
    logic [4:0]  cfg_edge = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        cfg_edge <= {cfg_stop2, cfg_parity, cfg_data_bits};
    end

    // Frame as a list of bit values: start, data LSB first, optional parity, stops
    function automatic int build_frame(input logic [7:0] d, input logic [4:0] cfg,
                                       output logic [11:0] bits);
        int nd, n, ones;
        nd = int'(cfg[1:0]) + 5;
        n = 0;
        ones = 0;
        bits = '1;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < nd; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (cfg[3:2] == 2'd1) begin
            bits[n] = 1'(ones % 2);
            n++;
        end else if (cfg[3:2] == 2'd2) begin
            bits[n] = 1'((ones + 1) % 2);
            n++;
        end
        n += cfg[4] ? 2 : 1;
        return n;
    endfunction

    int          seg_n = 0, seg_err = 0;
    string       seg_msg;

    task automatic chk(input string nm, input int got, input int exp);
        if (got != exp) begin
            if (seg_err == 0) seg_msg = $sformatf("cycle %0d %s got %0d want %0d", cyc, nm, got, exp);
            seg_err++;
        end
    endtask

    task automatic close_seg(input string what);
        if (seg_n > 0) begin
            vectors++;
            if (seg_err != 0) begin
                miscompares++;
                $display("FAIL %s: %0d bad samples, first at %s", what, seg_err, seg_msg);
            end
        end
        seg_n = 0;
        seg_err = 0;
    endtask

    task automatic expect_now(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    logic        act = 1'b0;
    int          fstart = 0, flen = 0, free_at = 0, qn;
    logic [11:0] fbits;
    logic [7:0]  fdata;
    logic [4:0]  fcfg;
    logic        exp_line;
    ent_t        e;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (act) begin
                    seg_n = 0;
                    seg_err = 0;
                    act = 1'b0;
                end else begin
                    close_seg("idle line");
                end
                sbq.delete();
                free_at = 0;
                continue;
            end
            if (act && cyc >= fstart + flen * SET) begin
                close_seg($sformatf("frame %02h dbits%0d par%0d stop2=%0d",
                                    fdata, int'(fcfg[1:0]) + 5, fcfg[3:2], fcfg[4]));
                act = 1'b0;
            end
            if (!act && sbq.size() > 0 && cyc >= sbq[0].acc + 1 && cyc >= free_at) begin
                close_seg("idle line");
                e       = sbq.pop_front();
                fdata   = e.d;
                fcfg    = cfg_edge;
                flen    = build_frame(fdata, fcfg, fbits);
                fstart  = cyc;
                free_at = cyc + flen * SET;
                act     = 1'b1;
            end
            exp_line = act ? fbits[(cyc - fstart) / SET] : 1'b1;
            qn = 0;
            foreach (sbq[i]) if (sbq[i].acc <= cyc) qn++;
            chk("serial_out",    int'(serial_out),    int'(exp_line));
            chk("fifo_count",    int'(fifo_count),    qn);
            chk("busy",          int'(busy),          int'(act || qn != 0));
            chk("data_in_ready", int'(data_in_ready), int'(qn != FD));
            seg_n++;
        end
    end

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] p, input logic s2);
        cfg_data_bits = db;
        cfg_parity    = p;
        cfg_stop2     = s2;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        data_in = b;
        data_in_valid = 1'b1;
        while (!data_in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!data_in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send %02h: ready never rose within %0d cycles", b, w);
        end else begin
            sbq.push_back('{b, cyc + 1});
            @(negedge clk);
        end
        data_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || act || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: timeout, %0d frames pending, busy=%0b", sbq.size(), busy);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int first_drop, t0, waitc;
        reset = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        set_cfg(2'd3, 2'd0, 1'b0);
        #1 reset = 1'b1;
        #2;
        expect_now("reset serial_out",    int'(serial_out),    1);
        expect_now("reset busy",          int'(busy),          0);
        expect_now("reset fifo_count",    int'(fifo_count),    0);
        expect_now("reset data_in_ready", int'(data_in_ready), 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        set_cfg(2'd3, 2'd0, 1'b0); send(8'hA5); drain();
        set_cfg(2'd2, 2'd1, 1'b1); send(8'h41); drain();
        set_cfg(2'd0, 2'd2, 1'b0); send(8'hFF); drain();

        // Valid held across six bytes: one is popped at once, four fill the FIFO
        set_cfg(2'd3, 2'd0, 1'b0);
        first_drop = -1;
        for (int i = 0; i < 6; i++) begin
            if (!data_in_ready && first_drop < 0) first_drop = i;
            send(8'(i * 37 + 11));
        end
        expect_now("bytes accepted before ready drop", first_drop, FD + 1);
        drain();

        set_cfg(2'd3, 2'd0, 1'b0);
        send(8'h96);
        send(8'h3B);
        repeat (30) @(negedge clk);
        set_cfg(2'd3, 2'd1, 1'b0);
        drain();

        // Reset 37 clocks into a frame with two bytes still queued
        set_cfg(2'd3, 2'd0, 1'b0);
        t0 = cyc + 2;
        send(8'h00);
        send(8'h5A);
        send(8'h3C);
        while (cyc < t0 + 37) @(negedge clk);
        expect_now("line low before reset", int'(serial_out), 0);
        #1 reset = 1'b1;
        #1;
        expect_now("async reset serial_out",    int'(serial_out),    1);
        expect_now("async reset fifo_count",    int'(fifo_count),    0);
        expect_now("async reset busy",          int'(busy),          0);
        expect_now("async reset data_in_ready", int'(data_in_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            send(8'($urandom));
            waitc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 150)) : 0;
            repeat (waitc) @(negedge clk);
        end
        drain();

        repeat (5) @(negedge clk);
        #1 close_seg("idle line");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
